// File: rtl/fwrisc_uart_pkg.sv
// Shared UART types and constants: TX state encoding, frame length, line levels.
package fwrisc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP,
        PARITY
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int FRAME_BITS     = 1 + UART_DATA_BITS + 1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate down-counter: ticks once every div+1 clocks; load restarts the count.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load || cnt == '0)
            cnt <= div;
        else
            cnt <= cnt - DIV_WIDTH'(1);
    end

    // A load cycle never counts as a bit boundary.
    assign tick = (cnt == '0) && !load;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops the TX FIFO and serializes 8N1 frames onto txd_o.
// Define UART_TX_PARITY_EN to add a parity bit (parity_odd_i selects odd/even).
module uart_tx_engine
    import fwrisc_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div_i,
    input  logic                  tx_en_i,
`ifdef UART_TX_PARITY_EN
    input  logic                  parity_odd_i,
`endif
    output logic                  tx_fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] tx_fifo_rdata_i,
    input  logic                  tx_fifo_empty_i,
    output logic                  txd_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state, next_state;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [IDX_W-1:0]      idx;
    logic [DIV_WIDTH-1:0]  div_q, cnt_div;
    logic                  tick, load, can_pop, last_bit;
    logic                  txd_q, txd_next;
`ifdef UART_TX_PARITY_EN
    logic                  par_q;
`endif

    assign can_pop  = tx_en_i && !tx_fifo_empty_i;
    assign last_bit = (idx == IDX_W'(DATA_WIDTH - 1));
    assign load     = (state == FETCH);
    // div_q is being written in FETCH, so the counter loads the live divisor then.
    assign cnt_div  = load ? baud_div_i : div_q;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .div   (cnt_div),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (can_pop) next_state = FETCH;
            FETCH: next_state = START;
            START: if (tick) next_state = DATA;
            DATA:  if (tick && last_bit)
`ifdef UART_TX_PARITY_EN
                       next_state = PARITY;
            PARITY: if (tick) next_state = STOP;
`else
                       next_state = STOP;
`endif
            STOP:  if (tick) next_state = can_pop ? FETCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_fifo_rd_en_o = 1'b0;
        tx_done_o       = 1'b0;
        tx_busy_o       = (state != IDLE);
        if (!reset) begin
            case (state)
                IDLE: tx_fifo_rd_en_o = can_pop;
                STOP: begin
                    tx_done_o       = tick;
                    tx_fifo_rd_en_o = tick && can_pop;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_next = shift;
        if (state == FETCH)
            shift_next = tx_fifo_rdata_i;
        else if (state == DATA && tick)
            shift_next = shift >> 1;
    end

    // txd is computed from the upcoming state so the flop lines up with it.
    always_comb begin
        txd_next = LINE_IDLE;
        case (next_state)
            START:  txd_next = LINE_START;
            DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY: txd_next = par_q;
`endif
            default: txd_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txd_q <= LINE_IDLE;
            shift <= '0;
            idx   <= '0;
            div_q <= '0;
        end else begin
            txd_q <= txd_next;
            shift <= shift_next;
            if (state == FETCH)
                div_q <= baud_div_i;
            if (state == START)
                idx <= '0;
            else if (state == DATA && tick)
                idx <= idx + IDX_W'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            par_q <= 1'b0;
        else if (state == FETCH)
            par_q <= (^tx_fifo_rdata_i) ^ parity_odd_i;
    end
`endif

    assign txd_o = txd_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed scenarios plus random traffic vs a timing model.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
    localparam int NB = fwrisc_uart_pkg::FRAME_BITS + 1;
`else
    localparam int NB = fwrisc_uart_pkg::FRAME_BITS;
`endif

    logic        clk = 1'b0;
    logic        reset, tx_en, rd_en, empty, txd, busy, done;
    logic [15:0] baud_div;
    logic [7:0]  rdata;
    logic        parity_odd;
    logic        pop_seen = 1'b0;

    always #5 clk = ~clk;

    uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .baud_div_i      (baud_div),
        .tx_en_i         (tx_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i    (parity_odd),
`endif
        .tx_fifo_rd_en_o (rd_en),
        .tx_fifo_rdata_i (rdata),
        .tx_fifo_empty_i (empty),
        .txd_o           (txd),
        .tx_busy_o       (busy),
        .tx_done_o       (done)
    );

    always @(posedge clk) pop_seen <= rd_en;

    logic [7:0] fq[$];   // FIFO contents seen by the DUT
    logic [7:0] mq[$];   // same bytes, consumed by the model
    int cyc, total, passed, failed;
    int cnt_rd, cnt_busy, cnt_done;

    // Model: a frame is a window of cycles after its pop cycle.
    bit          m_active, prev_rst, m_par_odd;
    int          m_p, m_len, m_div;
    logic [7:0]  m_byte;
    logic [NB-1:0] m_frame;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        mq.push_back(b);
        empty = 1'b0;
    endtask

    task automatic clr();
        cnt_rd = 0; cnt_busy = 0; cnt_done = 0;
    endtask

    task automatic step();
        int rel;
        logic e_txd, e_busy, e_done, e_rd, free;
        #1;
        if (reset) begin
            chk("rd_en_in_reset", rd_en, 0);
            chk("done_in_reset", done, 0);
            if (prev_rst) begin
                chk("txd_reset", txd, 1);
                chk("busy_reset", busy, 0);
            end
            m_active = 0;
            prev_rst = 1;
        end else begin
            e_txd = 1; e_busy = 0; e_done = 0; free = 1;
            if (m_active) begin
                rel = cyc - m_p;
                if (rel == 1) begin
                    m_div = int'(baud_div);
                    m_len = 1 + NB * (m_div + 1);
                    m_par_odd = parity_odd;
                    m_frame = '1;
                    m_frame[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[1+i] = m_byte[i];
`ifdef UART_TX_PARITY_EN
                    m_frame[9] = (($countones(m_byte) % 2) == 1) ^ m_par_odd;
`endif
                end
                e_busy = 1;
                free   = (rel == m_len);
                e_done = free;
                e_txd  = (rel == 1) ? 1'b1 : m_frame[(rel - 2) / (m_div + 1)];
            end
            e_rd = free && tx_en && (mq.size() > 0);
            chk("txd", txd, e_txd);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("rd_en", rd_en, e_rd);
            cnt_rd   += int'(rd_en);
            cnt_busy += int'(busy);
            cnt_done += int'(done);
            if (e_rd) begin
                m_active = 1;
                m_p      = cyc;
                m_byte   = mq.pop_front();
            end else if (free) begin
                m_active = 0;
            end
            prev_rst = 0;
        end
        @(negedge clk);
        cyc++;
        if (pop_seen && fq.size() > 0) rdata = fq.pop_front();
        empty = (fq.size() == 0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        reset = 1; tx_en = 1; baud_div = 16'd3; empty = 1; rdata = '0; parity_odd = 0;
        cyc = 0; total = 0; passed = 0; failed = 0;
        m_active = 0; prev_rst = 0; m_p = 0; m_len = 0; m_div = 0; m_byte = '0; m_frame = '1;
        clr();
        @(negedge clk);
        run(3);
        reset = 0;

        // empty FIFO, enabled
        clr(); run(100);
        chk("empty_rd", cnt_rd, 0);
        chk("empty_busy", cnt_busy, 0);

        // data waiting, disabled
        tx_en = 0; push(8'h5A);
        clr(); run(100);
        chk("dis_rd", cnt_rd, 0);
        chk("dis_busy", cnt_busy, 0);
        tx_en = 1;
        clr(); run(60);
        chk("en_rd", cnt_rd, 1);
        chk("en_busy", cnt_busy, 1 + NB * 4);

        // single byte, div=3
        push(8'hA5);
        clr(); run(60);
        chk("single_rd", cnt_rd, 1);
        chk("single_busy", cnt_busy, 1 + NB * 4);
        chk("single_done", cnt_done, 1);

        // back-to-back, div=0
        baud_div = 16'd0; push(8'h00); push(8'hFF);
        clr(); run(40);
        chk("b2b_rd", cnt_rd, 2);
        chk("b2b_busy", cnt_busy, 2 * (1 + NB));
        chk("b2b_done", cnt_done, 2);

        // divisor change during DATA of the first frame
        baud_div = 16'd3; push(8'h3C); push(8'hC3);
        clr(); run(15);
        baud_div = 16'd7;
        run(140);
        chk("div_rd", cnt_rd, 2);
        chk("div_busy", cnt_busy, (1 + NB * 4) + (1 + NB * 8));

        // reset during DATA bit 4; the popped byte is lost
        baud_div = 16'd3; push(8'h96);
        clr(); run(23);
        reset = 1; run(1); reset = 0;
        run(40);
        chk("rst_done", cnt_done, 0);
        chk("rst_rd", cnt_rd, 1);
        push(8'h5C);
        clr(); run(60);
        chk("post_rst_rd", cnt_rd, 1);
        chk("post_rst_done", cnt_done, 1);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1; push(8'h03);
        clr(); run(60);
        chk("par_busy", cnt_busy, 1 + 11 * 4);
        parity_odd = 0;
`endif

        // random traffic
        for (int it = 0; it < 300; it++) begin
            tx_en = ($urandom % 5) != 0;
            if ($urandom % 4 == 0) push(8'($urandom));
            if ($urandom % 8 == 0) baud_div = 16'($urandom_range(0, 3));
            parity_odd = $urandom % 2;
            run($urandom_range(1, 10));
        end
        tx_en = 1;
        run(4000);
        chk("drained", fq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Drains the UART TX FIFO, which the bus-side FIFO interface fills, and serializes each byte onto the txd line as an 8N1 frame (8 data bits, no parity, 1 stop bit).
- It is the only read-side master of the TX FIFO and sets the pace of FIFO consumption for the whole UART transmit path.
- A runtime baud divisor from the UART register block sets the bit period.

Parameters:
- DATA_WIDTH, 8: FIFO word and frame data width, LSB first.
- DIV_WIDTH, 16: width of the baud divisor.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- baud_div_i  input  DIV_WIDTH  bit period = baud_div_i+1 clocks.
- tx_en_i  input  1  enables starting new frames.
- tx_fifo_rd_en_o  output  1  one-cycle pop strobe to TX FIFO.
- tx_fifo_rdata_i  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_en.
- tx_fifo_empty_i  input  1  TX FIFO empty.
- txd_o  output  1  serial line, idle high.
- tx_busy_o  output  1  high from pop until end of stop bit.
- tx_done_o  output  1  one-cycle pulse at end of each stop bit.

Behaviour:
- Reset values: txd_o=1, tx_fifo_rd_en_o=0, tx_busy_o=0, tx_done_o=0. Reset forces state IDLE.
- Reset mid-frame aborts the frame immediately; txd_o returns to 1 on the next edge. The popped byte is lost.
- States: IDLE, FETCH, START, DATA, STOP (plus PARITY when the option below is compiled in).
- IDLE: if tx_en_i && !tx_fifo_empty_i, assert tx_fifo_rd_en_o for exactly one cycle and go to FETCH.
- FETCH (1 cycle):
  - Capture tx_fifo_rdata_i into the shift register.
  - Latch baud_div_i into div_q.
  - Load the baud counter with div_q.
  - Go to START.
- Baud counter:
  - Counts down from div_q to 0; bit_tick is the cycle the count is 0, then it reloads.
  - Each bit lasts exactly div_q+1 clocks. div=0 gives 1 clock per bit.
  - Changes to baud_div_i mid-frame have no effect until the next FETCH.
- START: txd_o=0 for one bit period; on bit_tick go to DATA with bit index 0.
- DATA:
  - txd_o = shift[0].
  - On bit_tick: shift right, index+1.
  - After index DATA_WIDTH-1 ticks, go to STOP.
- STOP: txd_o=1 for one bit period. On bit_tick:
  - Pulse tx_done_o.
  - If tx_en_i && !tx_fifo_empty_i, pop in the same cycle and go to FETCH (back-to-back frames, no idle bit).
  - Otherwise go to IDLE.
- tx_busy_o = 1 in FETCH, START, DATA, STOP (and PARITY); 0 in IDLE.
- Total frame time, FETCH to the end of STOP: 1 + 10*(div_q+1) clocks.
- Dropping tx_en_i mid-frame does not abort the frame; it only blocks the next pop.
- Empty FIFO: no pop is ever issued while tx_fifo_empty_i=1. An empty FIFO during STOP sends the engine to IDLE.
- txd_o is registered (driven from a flop); it never glitches combinationally.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd_i, sampled in FETCH.
  - Adds state PARITY between DATA and STOP.
  - PARITY drives ^data (even) or ~^data (odd) for one bit period.
  - Frame becomes 11 bits: 1 + 11*(div_q+1) clocks.
- Undefined: no parity port, no PARITY state; frame is 8N1 as above.

Decomposition:
- Package fwrisc_uart_pkg holds:
  - the tx_state_e enum (IDLE, FETCH, START, DATA, STOP, PARITY);
  - the localparam for frame bit count (START + DATA_WIDTH + STOP);
  - the idle line level constant.
- UART address constants stay in fwrisc_defines.vh.
- Sub-module uart_baud_tick holds the DIV_WIDTH down-counter:
  - inputs: clk, reset, load, div;
  - output: tick.
  - It is reused by the future RX engine.

Test Plan:
- Single byte: div=3, FIFO holds 0xA5, tx_en=1.
  - One rd_en pulse.
  - txd sequence, 4 clocks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - tx_done pulse 41 clocks after rd_en; busy for 41 clocks, then 0.
- Back-to-back: FIFO holds 0x00 and 0xFF, div=0.
  - Second rd_en coincides with the first STOP tick.
  - No idle-high gap beyond the stop bit.
  - Total 22 clocks of busy.
- Empty/disable:
  - FIFO empty, tx_en=1 for 100 cycles: no rd_en, txd=1, busy=0.
  - FIFO non-empty with tx_en=0: same result.
- Mid-frame divisor change: start with div=3; set div=7 during DATA.
  - Current frame keeps 4-clock bits.
  - Next frame uses 8-clock bits.
- Reset in DATA bit 4: txd=1 and busy=0 on the next edge; no tx_done pulse. After release, the next FIFO byte transmits normally.
- UART_TX_PARITY_EN, odd parity, byte 0x03: parity bit=1; frame is 11 bits.
